// File: rtl/cfg_slv.sv
// Config-link responder: receives 3-byte commands on RX_C and returns 2-byte responses on TX_C.
// Define CFG_SLV_TIMEOUT_EN to abort partial frames after TIMEOUT_CYC idle clocks between bytes.
module cfg_slv_uart #(
    parameter int BAUD_DIV = 434
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_rx,
    output logic       o_tx,
    input  logic       i_trmt,
    input  logic [7:0] i_tx_data,
    output logic       o_tx_done,
    output logic       o_rdy,
    output logic [7:0] o_rx_data,
    input  logic       i_clr_rdy
);
    localparam int CW = $clog2(BAUD_DIV + 1);
    localparam logic [CW-1:0] FULL = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] HALF = CW'(BAUD_DIV / 2);

    logic          r_rx_s1, r_rx_s2, r_rx_busy, r_rdy;
    logic [CW-1:0] r_rx_cnt;
    logic [3:0]    r_rx_bit;
    logic [7:0]    r_rx_shift, r_rx_data;
    logic          r_tx_busy, r_tx_done;
    logic [CW-1:0] r_tx_cnt;
    logic [3:0]    r_tx_bit;
    logic [9:0]    r_tx_shift;

    // Receiver: two-flop synchronizer, samples each bit at its midpoint
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_s1    <= 1'b1;
            r_rx_s2    <= 1'b1;
            r_rx_busy  <= 1'b0;
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
            r_rx_data  <= '0;
            r_rdy      <= 1'b0;
        end else begin
            r_rx_s1 <= i_rx;
            r_rx_s2 <= r_rx_s1;
            if (i_clr_rdy)
                r_rdy <= 1'b0;
            if (!r_rx_busy) begin
                if (!r_rx_s2) begin
                    r_rx_busy <= 1'b1;
                    r_rx_cnt  <= HALF;
                    r_rx_bit  <= '0;
                end
            end else if (r_rx_cnt != '0) begin
                r_rx_cnt <= r_rx_cnt - 1'b1;
            end else begin
                r_rx_cnt <= FULL;
                r_rx_bit <= r_rx_bit + 1'b1;
                if (r_rx_bit == 4'd0) begin
                    if (r_rx_s2)
                        r_rx_busy <= 1'b0;
                end else if (r_rx_bit == 4'd9) begin
                    r_rx_busy <= 1'b0;
                    if (r_rx_s2) begin
                        r_rx_data <= r_rx_shift;
                        r_rdy     <= 1'b1;
                    end
                end else begin
                    r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
                end
            end
        end
    end

    // Transmitter: the line is driven straight from bit 0 of the shift register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_busy  <= 1'b0;
            r_tx_done  <= 1'b0;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '1;
        end else begin
            r_tx_done <= 1'b0;
            if (!r_tx_busy) begin
                if (i_trmt) begin
                    r_tx_shift <= {1'b1, i_tx_data, 1'b0};
                    r_tx_busy  <= 1'b1;
                    r_tx_cnt   <= FULL;
                    r_tx_bit   <= '0;
                end
            end else if (r_tx_cnt != '0) begin
                r_tx_cnt <= r_tx_cnt - 1'b1;
            end else if (r_tx_bit == 4'd9) begin
                r_tx_busy <= 1'b0;
                r_tx_done <= 1'b1;
            end else begin
                r_tx_shift <= {1'b1, r_tx_shift[9:1]};
                r_tx_bit   <= r_tx_bit + 1'b1;
                r_tx_cnt   <= FULL;
            end
        end
    end

    assign o_tx      = r_tx_shift[0];
    assign o_tx_done = r_tx_done;
    assign o_rdy     = r_rdy;
    assign o_rx_data = r_rx_data;
endmodule

module cfg_slv #(
    parameter int BAUD_DIV = 434
`ifdef CFG_SLV_TIMEOUT_EN
    , parameter logic [23:0] TIMEOUT_CYC = 24'd2_500_000
`endif
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RX_C,
    output logic        TX_C,
    output logic [23:0] cmd,
    output logic        cmd_rdy,
    input  logic [15:0] resp,
    input  logic        snd_resp,
    output logic        resp_sent,
    output logic        frm_err
);
    typedef enum logic [2:0] {RX_H, RX_M, RX_L, CMD_VLD, TX_H, TX_L} state_t;

    state_t      r_state;
    logic [23:0] r_cmd;
    logic [15:0] r_shadow;
    logic        r_cmd_rdy, r_resp_sent, r_frm_err, r_trmt, r_clr_rdy;
    logic        w_rdy, w_rdy_ok, w_tx_done, w_timeout, w_rx_wait;
    logic [7:0]  w_rx_data, w_tx_data;

    cfg_slv_uart #(.BAUD_DIV(BAUD_DIV)) u_uart (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_rx      (RX_C),
        .o_tx      (TX_C),
        .i_trmt    (r_trmt),
        .i_tx_data (w_tx_data),
        .o_tx_done (w_tx_done),
        .o_rdy     (w_rdy),
        .o_rx_data (w_rx_data),
        .i_clr_rdy (r_clr_rdy)
    );

    // rdy stays high through the clr_rdy cycle, so it is masked to avoid a second capture
    assign w_rdy_ok  = w_rdy & ~r_clr_rdy;
    assign w_tx_data = (r_state == TX_L) ? r_shadow[7:0] : r_shadow[15:8];
    assign w_rx_wait = (r_state == RX_M) || (r_state == RX_L);

`ifdef CFG_SLV_TIMEOUT_EN
    logic [23:0] r_to_cnt;
    assign w_timeout = w_rx_wait && (r_to_cnt == TIMEOUT_CYC);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_to_cnt <= '0;
        else if (!w_rx_wait || w_rdy_ok || w_timeout)
            r_to_cnt <= '0;
        else
            r_to_cnt <= r_to_cnt + 1'b1;
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= RX_H;
            r_cmd       <= '0;
            r_shadow    <= '0;
            r_cmd_rdy   <= 1'b0;
            r_resp_sent <= 1'b0;
            r_frm_err   <= 1'b0;
            r_trmt      <= 1'b0;
            r_clr_rdy   <= 1'b0;
        end else begin
            r_trmt      <= 1'b0;
            r_clr_rdy   <= 1'b0;
            r_resp_sent <= 1'b0;
            if (snd_resp)
                r_frm_err <= 1'b0;
            case (r_state)
                RX_H: if (w_rdy_ok) begin
                    r_cmd[23:16] <= w_rx_data;
                    r_clr_rdy    <= 1'b1;
                    r_state      <= RX_M;
                end
                RX_M: if (w_rdy_ok) begin
                    r_cmd[15:8] <= w_rx_data;
                    r_clr_rdy   <= 1'b1;
                    r_state     <= RX_L;
                end else if (w_timeout) begin
                    r_frm_err <= 1'b1;
                    r_state   <= RX_H;
                end
                RX_L: if (w_rdy_ok) begin
                    r_cmd[7:0] <= w_rx_data;
                    r_clr_rdy  <= 1'b1;
                    r_state    <= CMD_VLD;
                end else if (w_timeout) begin
                    r_frm_err <= 1'b1;
                    r_state   <= RX_H;
                end
                CMD_VLD: if (!r_cmd_rdy) begin
                    r_cmd_rdy <= 1'b1;
                end else if (snd_resp) begin
                    r_shadow  <= resp;
                    r_trmt    <= 1'b1;
                    r_cmd_rdy <= 1'b0;
                    r_state   <= TX_H;
                end
                TX_H: if (w_tx_done) begin
                    r_trmt  <= 1'b1;
                    r_state <= TX_L;
                end
                TX_L: if (w_tx_done) begin
                    r_resp_sent <= 1'b1;
                    r_state     <= RX_H;
                end
                default: r_state <= RX_H;
            endcase
            // Bytes arriving while a command is pending or being answered are dropped
            if (w_rdy_ok && (r_state == CMD_VLD || r_state == TX_H || r_state == TX_L)) begin
                r_clr_rdy <= 1'b1;
                r_frm_err <= 1'b1;
            end
        end
    end

    assign cmd       = r_cmd;
    assign cmd_rdy   = r_cmd_rdy;
    assign resp_sent = r_resp_sent;
    assign frm_err   = r_frm_err;
endmodule

// File: tb/tb_cfg_slv.sv
// Directed bench for cfg_slv: table-driven frames plus hand-written corner sequences.
`timescale 1ns/1ps
module tb_cfg_slv;
    localparam int BAUD = 16;

    logic        clk, rst_n, RX_C, TX_C, cmd_rdy, snd_resp, resp_sent, frm_err;
    logic [23:0] cmd;
    logic [15:0] resp;

    int total = 0;
    int bad = 0;
    int sent_cnt = 0;

    cfg_slv #(
        .BAUD_DIV(BAUD)
`ifdef CFG_SLV_TIMEOUT_EN
        , .TIMEOUT_CYC(24'd1000)
`endif
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .RX_C      (RX_C),
        .TX_C      (TX_C),
        .cmd       (cmd),
        .cmd_rdy   (cmd_rdy),
        .resp      (resp),
        .snd_resp  (snd_resp),
        .resp_sent (resp_sent),
        .frm_err   (frm_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (resp_sent === 1'b1) sent_cnt++;

    initial begin
        #800us;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    typedef struct {
        logic [7:0]  b0, b1, b2;
        logic [15:0] r;
        logic [23:0] ecmd;
        logic [7:0]  ehi, elo;
    } vec_t;
    vec_t vt[3];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        RX_C = 1'b0;
        repeat (BAUD) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            RX_C = b[i];
            repeat (BAUD) @(negedge clk);
        end
        RX_C = 1'b1;
        repeat (BAUD) @(negedge clk);
    endtask

    // Sends three bytes and checks that cmd_rdy rises two clocks after the last rdy
    task automatic send_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        send_byte(a);
        send_byte(b);
        fork
            send_byte(c);
            begin : mon
                int n;
                n = 0;
                while (dut.w_rdy !== 1'b1 && n < 20 * BAUD) begin
                    @(negedge clk);
                    n++;
                end
                chk("rdy_seen", 32'(dut.w_rdy), 32'd1);
                chk("cmd_rdy_t0", 32'(cmd_rdy), 32'd0);
                @(negedge clk);
                chk("cmd_rdy_t1", 32'(cmd_rdy), 32'd0);
                @(negedge clk);
                chk("cmd_rdy_t2", 32'(cmd_rdy), 32'd1);
            end
        join
    endtask

    task automatic recv_byte(output logic [7:0] b, output bit ok);
        int n;
        n = 0;
        b = '0;
        while (TX_C !== 1'b0 && n < 40 * BAUD) begin
            @(negedge clk);
            n++;
        end
        if (TX_C !== 1'b0) begin
            ok = 1'b0;
            return;
        end
        repeat (BAUD / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            repeat (BAUD) @(negedge clk);
            b[i] = TX_C;
        end
        repeat (BAUD) @(negedge clk);
        ok = (TX_C === 1'b1);
    endtask

    task automatic respond(input logic [15:0] r, input logic [7:0] ehi, input logic [7:0] elo);
        int s0, n;
        logic [7:0] got;
        bit ok;
        s0 = sent_cnt;
        resp = r;
        snd_resp = 1'b1;
        @(negedge clk);
        snd_resp = 1'b0;
        resp = 16'h0000;
        chk("cmd_rdy_drop", 32'(cmd_rdy), 32'd0);
        chk("frm_err_clr", 32'(frm_err), 32'd0);
        recv_byte(got, ok);
        chk("tx_hi_frame", 32'(ok), 32'd1);
        chk("tx_hi", 32'(got), 32'(ehi));
        recv_byte(got, ok);
        chk("tx_lo_frame", 32'(ok), 32'd1);
        chk("tx_lo", 32'(got), 32'(elo));
        n = 0;
        while (sent_cnt == s0 && n < 4 * BAUD) begin
            @(negedge clk);
            n++;
        end
        chk("resp_sent_pulse", 32'(sent_cnt - s0), 32'd1);
        repeat (2 * BAUD) @(negedge clk);
        chk("resp_sent_once", 32'(sent_cnt - s0), 32'd1);
    endtask

    initial begin : main
        int s0;
        int lows;
        vt[0] = '{b0: 8'hA5, b1: 8'h3C, b2: 8'h0F, r: 16'hBEEF, ecmd: 24'hA53C0F, ehi: 8'hBE, elo: 8'hEF};
        vt[1] = '{b0: 8'h00, b1: 8'hFF, b2: 8'h81, r: 16'h1234, ecmd: 24'h00FF81, ehi: 8'h12, elo: 8'h34};
        vt[2] = '{b0: 8'hFF, b1: 8'h00, b2: 8'h7E, r: 16'hA001, ecmd: 24'hFF007E, ehi: 8'hA0, elo: 8'h01};

        rst_n = 1'b0;
        RX_C = 1'b1;
        resp = 16'h0000;
        snd_resp = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_tx", 32'(TX_C), 32'd1);
        chk("rst_cmd", 32'(cmd), 32'd0);
        chk("rst_cmd_rdy", 32'(cmd_rdy), 32'd0);
        chk("rst_resp_sent", 32'(resp_sent), 32'd0);
        chk("rst_frm_err", 32'(frm_err), 32'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        for (int i = 0; i < 3; i++) begin
            send_frame(vt[i].b0, vt[i].b1, vt[i].b2);
            repeat (2) @(negedge clk);
            chk($sformatf("v%0d_cmd", i), 32'(cmd), 32'(vt[i].ecmd));
            chk($sformatf("v%0d_frm_err", i), 32'(frm_err), 32'd0);
            respond(vt[i].r, vt[i].ehi, vt[i].elo);
        end

        // snd_resp while only the high byte has arrived is ignored
        send_byte(8'h5B);
        repeat (4) @(negedge clk);
        resp = 16'hFFFF;
        snd_resp = 1'b1;
        @(negedge clk);
        snd_resp = 1'b0;
        lows = 0;
        repeat (3 * BAUD) begin
            @(negedge clk);
            if (TX_C !== 1'b1) lows++;
        end
        chk("rxm_tx_idle", 32'(lows), 32'd0);
        chk("rxm_cmd_hi", 32'(cmd[23:16]), 32'h5B);
        chk("rxm_cmd_rdy", 32'(cmd_rdy), 32'd0);
        send_byte(8'h6C);
        send_byte(8'h7D);
        repeat (4) @(negedge clk);
        chk("rxm_cmd", 32'(cmd), 32'h5B6C7D);
        chk("rxm_cmd_rdy_done", 32'(cmd_rdy), 32'd1);
        chk("rxm_frm_err", 32'(frm_err), 32'd0);
        respond(16'h0102, 8'h01, 8'h02);

        // Extra byte while a command is pending is dropped and flagged
        send_frame(8'hA5, 8'h3C, 8'h0F);
        repeat (2) @(negedge clk);
        send_byte(8'h77);
        repeat (4) @(negedge clk);
        chk("extra_cmd", 32'(cmd), 32'hA53C0F);
        chk("extra_frm_err", 32'(frm_err), 32'd1);
        chk("extra_cmd_rdy", 32'(cmd_rdy), 32'd1);
        respond(16'hC396, 8'hC3, 8'h96);

        // Reset in the middle of the first response byte
        send_frame(8'h11, 8'h22, 8'h33);
        repeat (2) @(negedge clk);
        chk("pre_rst_cmd", 32'(cmd), 32'h112233);
        resp = 16'hBEEF;
        snd_resp = 1'b1;
        @(negedge clk);
        snd_resp = 1'b0;
        lows = 0;
        while (TX_C !== 1'b0 && lows < 4 * BAUD) begin
            @(negedge clk);
            lows++;
        end
        chk("pre_rst_tx_start", 32'(TX_C), 32'd0);
        repeat (3 * BAUD) @(negedge clk);
        s0 = sent_cnt;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_tx", 32'(TX_C), 32'd1);
        chk("mid_rst_cmd", 32'(cmd), 32'd0);
        chk("mid_rst_cmd_rdy", 32'(cmd_rdy), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        lows = 0;
        repeat (30 * BAUD) begin
            @(negedge clk);
            if (TX_C !== 1'b1) lows++;
        end
        chk("post_rst_tx_idle", 32'(lows), 32'd0);
        chk("post_rst_no_sent", 32'(sent_cnt - s0), 32'd0);
        chk("post_rst_frm_err", 32'(frm_err), 32'd0);
        send_frame(8'hA5, 8'h3C, 8'h0F);
        repeat (2) @(negedge clk);
        chk("post_rst_cmd", 32'(cmd), 32'hA53C0F);
        respond(16'h5AC3, 8'h5A, 8'hC3);

`ifdef CFG_SLV_TIMEOUT_EN
        // Stalled frame is abandoned; the next byte starts a new frame
        send_byte(8'h11);
        repeat (1000) @(negedge clk);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h44);
        repeat (4) @(negedge clk);
        chk("to_frm_err", 32'(frm_err), 32'd1);
        chk("to_cmd", 32'(cmd), 32'h223344);
        chk("to_cmd_rdy", 32'(cmd_rdy), 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
